// File: rtl/mem_stage_ctrl_if.sv
// Data-RAM request/acknowledge bus between the MEM stage and data memory.
`timescale 1ns/1ps
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: RAM_CTRL decode, req/ack data-RAM access, big-endian load
// extraction, pipeline stall and sticky fault reporting.
`timescale 1ns/1ps
module mem_stage_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ex_out,
  input  logic [31:0] ex_di,
  input  logic [4:0]  ex_rd,
  input  logic        l,
  input  logic        rf_le,
  input  logic [3:0]  ram_ctrl,
  mem_stage_ctrl_if.master bus,
  output logic        stall,
  output logic [31:0] mem_out,
  output logic [4:0]  mem_rd,
  output logic        mem_rf_le,
  output logic [1:0]  fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   capt;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          tout_q;

  logic [1:0]    off;
  logic [1:0]    size;
  logic          en;
  logic          wr;
  logic          bad;
  logic          go;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   ext;

  assign off    = ex_out[1:0];
  assign size   = ram_ctrl[1:0];
  assign en     = ram_ctrl[3];
  assign wr     = ram_ctrl[2];
  assign go     = en & ~bad;
  assign mem_rd = ex_rd;

  always_comb begin
    bad = 1'b1;
    unique case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = |off;
      default: bad = 1'b1;
    endcase
  end

  // Loads read the whole word; lanes are picked out on ack.
  always_comb begin
    be_c    = 4'hF;
    wdata_c = ex_di;
    unique case (1'b1)
      size == 2'b00: begin
        be_c    = 4'b1000 >> off;
        wdata_c = {4{ex_di[7:0]}};
      end
      size == 2'b01: begin
        be_c    = off[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{ex_di[15:0]}};
      end
      default: ;
    endcase
    if (!wr) be_c = 4'hF;
  end

  // Offset 0 is the most significant lane.
  always_comb begin
    ext = bus.mem_rdata;
    unique case (size_q)
      2'b00:   ext = (bus.mem_rdata >> {~off_q, 3'b000}) & 32'hFF;
      2'b01:   ext = off_q[1] ? {16'h0, bus.mem_rdata[15:0]}
                              : {16'h0, bus.mem_rdata[31:16]};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      capt          <= '0;
      off_q         <= '0;
      size_q        <= '0;
      we_q          <= 1'b0;
      tout_q        <= 1'b0;
      fault         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= wr;
            bus.mem_addr  <= {ex_out[ADDR_W-1:2], 2'b00};
            bus.mem_be    <= be_c;
            bus.mem_wdata <= wdata_c;
            off_q         <= off;
            size_q        <= size;
            we_q          <= wr;
            tout_q        <= 1'b0;
            cnt           <= '0;
            state         <= WAIT;
          end else if (en) begin
            fault[0] <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            if (!we_q) capt <= ext;
            bus.mem_req <= 1'b0;
            state       <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            fault[1]    <= 1'b1;
            tout_q      <= 1'b1;
            capt        <= '0;
            bus.mem_req <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall     = 1'b0;
    mem_out   = ex_out;
    mem_rf_le = rf_le;
    if (!reset) begin
      mem_rf_le = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            stall     = go;
            mem_rf_le = 1'b0;
          end
        end
        WAIT: begin
          stall     = 1'b1;
          mem_rf_le = 1'b0;
        end
        DONE: begin
          mem_rf_le = rf_le & ~tout_q;
          if (l & ~we_q) mem_out = capt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: random ops, RAM responder,
// reference memory image and negedge monitor.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ex_out = '0;
  logic [31:0] ex_di = '0;
  logic [4:0]  ex_rd = '0;
  logic        l = 1'b0;
  logic        rf_le = 1'b0;
  logic [3:0]  ram_ctrl = '0;
  logic        stall;
  logic [31:0] mem_out;
  logic [4:0]  mem_rd;
  logic        mem_rf_le;
  logic [1:0]  fault;

  mem_stage_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  logic        resp_en = 1'b1;
  logic        r_ack = 1'b0;
  logic        d_ack = 1'b0;
  logic [31:0] r_rdata = '0;
  assign bus.mem_ack   = resp_en ? r_ack : d_ack;
  assign bus.mem_rdata = r_rdata;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ex_out(ex_out), .ex_di(ex_di), .ex_rd(ex_rd),
    .l(l), .rf_le(rf_le), .ram_ctrl(ram_ctrl),
    .bus(bus),
    .stall(stall), .mem_out(mem_out), .mem_rd(mem_rd),
    .mem_rf_le(mem_rf_le), .fault(fault)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } exp_req_t;

  typedef struct {
    logic [31:0] out;
    logic [4:0]  rd;
    logic        rf;
    logic [1:0]  flt;
    int          stalls;
  } exp_res_t;

  exp_req_t req_q[$];
  exp_res_t res_q[$];
  int       dly_q[$];

  int vecs = 0;
  int miscmp = 0;
  logic mon_en = 1'b0;
  logic [31:0] ram[64];
  logic [31:0] ref_mem[64];
  logic [1:0] f_model = 2'b00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: request fields and length, then retirement on stall=0.
  exp_req_t cur_req;
  exp_res_t cur_res;
  int  req_len = 0;
  int  stall_cnt = 0;
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (bus.mem_req) begin
        if (!req_prev) begin
          req_len = 0;
          if (req_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
            cur_req = '{8'h0, 4'h0, 1'b0, 32'h0, 0};
          end else begin
            cur_req = req_q.pop_front();
          end
        end
        req_len++;
        chk("mem_addr", 32'(bus.mem_addr), 32'(cur_req.addr));
        chk("mem_be", 32'(bus.mem_be), 32'(cur_req.be));
        chk("mem_we", 32'(bus.mem_we), 32'(cur_req.we));
        chk("mem_wdata", bus.mem_wdata, cur_req.wdata);
      end else if (req_prev) begin
        chk("req_len", req_len, cur_req.len);
      end
      req_prev = bus.mem_req;
      if (stall) begin
        stall_cnt++;
      end else if (res_q.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        cur_res = res_q.pop_front();
        chk("mem_out", mem_out, cur_res.out);
        chk("mem_rd", 32'(mem_rd), 32'(cur_res.rd));
        chk("mem_rf_le", 32'(mem_rf_le), 32'(cur_res.rf));
        chk("fault", 32'(fault), 32'(cur_res.flt));
        chk("stall_cycles", stall_cnt, cur_res.stalls);
        stall_cnt = 0;
      end
    end
  end

  // RAM responder: ack after a per-op delay chosen by the stimulus.
  int wc = 0;
  int cur_dly = 0;
  always @(posedge clk) begin
    #1;
    if (!reset || !resp_en) begin
      wc = 0;
      r_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (wc == 0) cur_dly = (dly_q.size() != 0) ? dly_q.pop_front() : 999;
      if (wc == cur_dly) begin
        r_ack = 1'b1;
        if (bus.mem_we) begin
          for (int k = 0; k < 4; k++)
            if (bus.mem_be[3-k])
              ram[bus.mem_addr[7:2]][31-8*k -: 8] = bus.mem_wdata[31-8*k -: 8];
          r_rdata = $urandom;
        end else begin
          r_rdata = ram[bus.mem_addr[7:2]];
        end
      end else begin
        r_ack = 1'b0;
        r_rdata = $urandom;
      end
      wc++;
    end else begin
      wc = 0;
      r_ack = ($urandom_range(3) == 0);
      r_rdata = $urandom;
    end
  end

  function automatic logic [31:0] lane(input logic [31:0] w, input int sz,
                                       input int off);
    if (sz == 0) return (w >> (24 - 8 * off)) & 32'hFF;
    if (sz == 1) return (w >> (16 - 8 * off)) & 32'hFFFF;
    return w;
  endfunction

  task automatic issue(input logic [3:0] rc, input logic [31:0] eo,
                       input logic [31:0] di, input logic [4:0] rd,
                       input logic ll, input logic rf, input int dly);
    int off, sz, widx, c;
    bit legal, to;
    exp_res_t r;
    exp_req_t q;
    off  = int'(eo[1:0]);
    sz   = int'(rc[1:0]);
    widx = int'(eo[7:2]);
    legal = (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
    r = '{eo, rd, rf, f_model, 0};
    if (rc[3] && !legal) begin
      r.rf = 1'b0;
      f_model[0] = 1'b1;
    end else if (rc[3]) begin
      to = (dly >= TIMEOUT);
      q.len = to ? TIMEOUT : dly + 1;
      r.stalls = 1 + q.len;
      q.addr = eo[7:0] & 8'hFC;
      q.we = rc[2];
      if (sz == 0) begin
        q.be = 4'(1 << (3 - off));
        q.wdata = 32'h01010101 * {24'h0, di[7:0]};
      end else if (sz == 1) begin
        q.be = 4'(3 << (2 - off));
        q.wdata = 32'h00010001 * {16'h0, di[15:0]};
      end else begin
        q.be = 4'hF;
        q.wdata = di;
      end
      if (!rc[2]) q.be = 4'hF;
      if (to) f_model[1] = 1'b1;
      r.flt = f_model;
      r.rf = rf & !to;
      if (!rc[2]) begin
        if (ll) r.out = to ? 32'h0 : lane(ref_mem[widx], sz, off);
      end else if (!to) begin
        for (int k = 0; k < 4; k++)
          if (q.be[3-k]) ref_mem[widx][31-8*k -: 8] = q.wdata[31-8*k -: 8];
      end
      req_q.push_back(q);
      dly_q.push_back(dly);
    end
    res_q.push_back(r);
    ram_ctrl = rc; ex_out = eo; ex_di = di; ex_rd = rd; l = ll; rf_le = rf;
    c = 0;
    @(negedge clk);
    while (stall && c < 40) begin
      c++;
      @(negedge clk);
    end
    if (stall) chk("stall_budget", 32'(c), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rc;
    logic [31:0] eo;
    int d, r;
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[0] = 32'hAABBCCDD;
    ref_mem[0] = 32'hAABBCCDD;

    ram_ctrl = 4'b1010; rf_le = 1'b1; ex_out = 32'h40;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rf_le", 32'(mem_rf_le), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    ram_ctrl = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;

    issue(4'b0000, 32'h12345678, 32'h0, 5'd5, 1'b0, 1'b1, 0);
    issue(4'b1000, 32'h00000003, 32'h0, 5'd1, 1'b1, 1'b1, 0);
    issue(4'b1101, 32'h00000012, 32'h0000BEEF, 5'd2, 1'b0, 1'b0, 1);
    issue(4'b1010, 32'h00000006, 32'h0, 5'd3, 1'b1, 1'b1, 0);
    issue(4'b0000, 32'hCAFE0000, 32'h0, 5'd4, 1'b0, 1'b1, 0);
    issue(4'b1010, 32'h00000020, 32'h0, 5'd6, 1'b1, 1'b1, 99);
    issue(4'b1001, 32'h00000010, 32'h0, 5'd8, 1'b1, 1'b1, TIMEOUT - 1);

    for (int n = 0; n < 300; n++) begin
      rc = 4'($urandom);
      if ($urandom_range(3) == 0) rc[3] = 1'b0;
      eo = $urandom;
      if ($urandom_range(1) == 1) begin
        if (rc[1:0] == 2'b10) eo[1:0] = 2'b00;
        else if (rc[1:0] == 2'b01) eo[0] = 1'b0;
      end
      r = $urandom_range(19);
      if (r < 14) d = r % 4;
      else if (r < 17) d = TIMEOUT - 1;
      else if (r == 17) d = TIMEOUT;
      else d = 40;
      issue(rc, eo, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), d);
    end
    mon_en = 1'b0;

    resp_en = 1'b0;
    d_ack = 1'b0;
    ram_ctrl = 4'b1010; ex_out = 32'h40; l = 1'b1; rf_le = 1'b1; ex_rd = 5'd7;
    @(posedge clk);
    #1;
    chk("rw_req_wait1", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_stall_in_rst", 32'(stall), 32'd0);
    chk("rw_rf_le_in_rst", 32'(mem_rf_le), 32'd0);
    @(posedge clk);
    #1;
    chk("rw_req_dropped", 32'(bus.mem_req), 32'd0);
    chk("rw_fault", 32'(fault), 32'd0);
    reset = 1'b1;
    d_ack = 1'b1;
    ram_ctrl = 4'b0000; ex_out = 32'h12345678; rf_le = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rw_late_ack_req", 32'(bus.mem_req), 32'd0);
      chk("rw_late_ack_stall", 32'(stall), 32'd0);
      chk("rw_idle_out", mem_out, 32'h12345678);
      chk("rw_no_wb", 32'(mem_rf_le), 32'd0);
      chk("rw_fault_clear", 32'(fault), 32'd0);
    end
    chk("req_q_drained", req_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
